alu_issue_queue: RTL and testbench

//  Request buffer directly upstream of the registered 32-bit ALU.
//  - Accepts {inst, a, b} operation requests over a valid/ready handshake and stores them in a FIFO.
//  - Issues at most one request per cycle to the ALU input (i_valid/i_inst/i_data_a/i_data_b) while i_issue_en is high.
//  - Discards inst 4'd15 at the input; the ALU has no meaning for it. Counts each discard.

---
 rtl/alu_issue_queue.sv | 114 +++++++++++
 tb/tb_alu_issue_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Request FIFO in front of the registered ALU: accepts {inst,a,b} over
// valid/ready, drops opcode 15 (with a saturating drop counter), and
// issues at most one registered request per cycle while i_issue_en is high.
// Ports: i_clk/i_rst_n; request side i_req_*/o_req_ready; issue side
// i_issue_en/o_alu_*; status o_count/o_full/o_empty/o_drop_cnt.
module alu_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 4,
    parameter int DEPTH      = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic [DATA_WIDTH-1:0]       i_req_a,
    input  logic [DATA_WIDTH-1:0]       i_req_b,
    input  logic [INST_WIDTH-1:0]       i_req_inst,
    input  logic                        i_issue_en,
    output logic                        o_alu_valid,
    output logic [DATA_WIDTH-1:0]       o_alu_a,
    output logic [DATA_WIDTH-1:0]       o_alu_b,
    output logic [INST_WIDTH-1:0]       o_alu_inst,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [7:0]                  o_drop_cnt
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [INST_WIDTH-1:0] INST_ILLEGAL = INST_WIDTH'(15);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT     = (ADDR_WIDTH+1)'(DEPTH);

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  alu_valid_q, alu_valid_d;
    entry_t                alu_q, alu_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic accept, illegal, push, drop, pop;

    // Status is decoded from the count register only, so ready has no
    // combinational dependence on any input.
    assign o_full      = (count_q == FULL_CNT);
    assign o_empty     = (count_q == '0);
    assign o_req_ready = ~o_full;
    assign o_count     = count_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_alu_valid = alu_valid_q;
    assign o_alu_a     = alu_q.a;
    assign o_alu_b     = alu_q.b;
    assign o_alu_inst  = alu_q.inst;

    always_comb begin
        accept      = i_req_valid & o_req_ready;
        illegal     = (i_req_inst == INST_ILLEGAL);
        push        = accept & ~illegal;
        drop        = accept & illegal;
        pop         = i_issue_en & ~o_empty;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        alu_valid_d = pop;
        alu_d       = alu_q;
        drop_cnt_d  = drop_cnt_q;

        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            alu_d    = mem_q[rd_ptr_q];
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= '{inst: i_req_inst, a: i_req_a, b: i_req_b};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_valid_q <= 1'b0;
            alu_q       <= '0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_valid_q <= alu_valid_d;
            alu_q       <= alu_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: the driver predicts accepts/pops
// and queues expected issues; a negedge monitor pops and compares.
module tb_alu_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_inst;
    logic        issue_en;
    logic        alu_valid;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_inst;
    logic [3:0]  count;
    logic        full, empty;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    alu_issue_queue dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_inst  (req_inst),
        .i_issue_en  (issue_en),
        .o_alu_valid (alu_valid),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_inst  (alu_inst),
        .o_count     (count),
        .o_full      (full),
        .o_empty     (empty),
        .o_drop_cnt  (drop_cnt)
    );

    typedef struct {
        logic [3:0]  inst;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   mcount = 0;
    int   mdrop = 0;
    bit   mvalid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // One cycle: check state predicted by the model, drive, advance model.
    task automatic step(input bit v, input logic [3:0] inst,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit en);
        bit acc;
        bit pop;
        bit lpush;
        @(negedge clk);
        chk("count", 32'(count), 32'(mcount));
        chk("full", 32'(full), 32'(mcount == 8));
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("ready", 32'(req_ready), 32'(mcount != 8));
        chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
        chk("alu_valid", 32'(alu_valid), 32'(mvalid));
        req_valid = v;
        req_inst  = inst;
        req_a     = a;
        req_b     = b;
        issue_en  = en;
        acc   = v && (mcount != 8);
        pop   = en && (mcount != 0);
        lpush = acc && (inst != 4'd15);
        if (acc && inst == 4'd15 && mdrop != 255) mdrop++;
        if (lpush) sb.push_back('{inst, a, b});
        mvalid = pop;
        mcount = mcount + int'(lpush) - int'(pop);
    endtask

    task automatic idle(input bit en);
        step(1'b0, 4'd0, 32'd0, 32'd0, en);
    endtask

    always @(negedge clk) begin
        if (rst_n && alu_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue actual=%0h/%0h/%0h expected=none",
                         alu_inst, alu_a, alu_b);
            end else begin
                mon_e = sb.pop_front();
                chk("issue_inst", 32'(alu_inst), 32'(mon_e.inst));
                chk("issue_a", alu_a, mon_e.a);
                chk("issue_b", alu_b, mon_e.b);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_inst = '0;
        req_a = '0;
        req_b = '0;
        issue_en = 1'b0;
        #1;
        chk("rst_valid", 32'(alu_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-traffic with a live issue and a nonzero drop count.
        step(1'b1, 4'd15, 32'd1, 32'd1, 1'b1);
        step(1'b1, 4'd3, 32'hA, 32'hB, 1'b1);
        step(1'b1, 4'd1, 32'hC, 32'hD, 1'b0);
        step(1'b1, 4'd2, 32'hE, 32'hF, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        req_valid = 1'b0;
        issue_en = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(alu_valid), 32'd0);
        chk("mid_rst_a", alu_a, 32'd0);
        chk("mid_rst_b", alu_b, 32'd0);
        chk("mid_rst_inst", 32'(alu_inst), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        sb.delete();
        mcount = 0;
        mdrop = 0;
        mvalid = 1'b0;
        #3 rst_n = 1'b1;

        // Single op, issues one edge after accept.
        step(1'b1, 4'd0, 32'd5, 32'd7, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Fill while stalled; the ninth request is refused.
        for (int i = 0; i < 9; i++)
            step(1'b1, 4'(i % 15), 32'(100 + i), 32'(200 + i), 1'b0);
        idle(1'b0);
        for (int i = 0; i < 10; i++) idle(1'b1);

        // Back-to-back throughput across pointer wraps.
        for (int i = 0; i < 20; i++)
            step(1'b1, 4'(i % 15), 32'(1000 + i), 32'(~i), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Drops interleaved with legal ops; counter saturates.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 4'd15, 32'(i), 32'(i), 1'b1);
            step(1'b1, 4'($urandom_range(14)), $urandom, $urandom, 1'b1);
        end
        idle(1'b1);
        idle(1'b1);
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Random valid/issue_en against the model.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(1)),
                 ($urandom_range(7) == 0) ? 4'd15 : 4'($urandom_range(14)),
                 $urandom, $urandom, 1'($urandom_range(1)));

        for (int i = 0; i < 12; i++) idle(1'b1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
